// File: rtl/expr_eval.sv
// Streaming left-to-right evaluator for "digit (op digit)* =" expressions.
// Takes one ASCII character per valid cycle and reports a 16-bit result or an error on each '='.
module expr_eval (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        in_valid,
    input  logic [7:0]  in,
    output logic        done,
    output logic        err,
    output logic [15:0] result
);

    typedef enum logic [1:0] {StStart, StOpnd, StOper, StErr} state_e;

    localparam logic [7:0] ChPlus  = 8'h2B;
    localparam logic [7:0] ChMinus = 8'h2D;
    localparam logic [7:0] ChMul   = 8'h2A;
    localparam logic [7:0] ChEq    = 8'h3D;
    localparam logic [7:0] ChZero  = 8'h30;
    localparam logic [7:0] ChNine  = 8'h39;

    state_e      r_state;
    logic [15:0] r_acc;
    logic [7:0]  r_op;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_result;

    logic        w_is_digit;
    logic        w_is_op;
    logic        w_is_term;
    logic [7:0]  w_digit8;
    logic [15:0] w_digit;
    logic [15:0] w_calc;

    assign w_is_digit = (in >= ChZero) && (in <= ChNine);
    assign w_is_op    = (in == ChPlus) || (in == ChMinus) || (in == ChMul);
    assign w_is_term  = (in == ChEq);
    assign w_digit8   = in - ChZero;
    assign w_digit    = {8'h00, w_digit8};

    // Wraps modulo 2^16; only the low half of the product is kept.
    always_comb begin
        w_calc = r_acc + w_digit;
        case (r_op)
            ChMinus: w_calc = r_acc - w_digit;
            ChMul:   w_calc = r_acc * w_digit;
            default: w_calc = r_acc + w_digit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state  <= StStart;
            r_acc    <= 16'h0000;
            r_op     <= ChPlus;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    StStart: begin
                        if (w_is_digit) begin
                            r_state <= StOpnd;
                            r_acc   <= w_digit;
                        end else if (w_is_term) begin
                            r_state  <= StStart;
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_result <= 16'h0000;
                        end else begin
                            r_state <= StErr;
                        end
                    end
                    StOpnd: begin
                        if (w_is_op) begin
                            r_state <= StOper;
                            r_op    <= in;
                        end else if (w_is_term) begin
                            r_state  <= StStart;
                            r_done   <= 1'b1;
                            r_err    <= 1'b0;
                            r_result <= r_acc;
                        end else begin
                            r_state <= StErr;
                        end
                    end
                    StOper: begin
                        if (w_is_digit) begin
                            r_state <= StOpnd;
                            r_acc   <= w_calc;
                        end else if (w_is_term) begin
                            r_state  <= StStart;
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_result <= 16'h0000;
                        end else begin
                            r_state <= StErr;
                        end
                    end
                    default: begin
                        // Sticky until '=' closes the bad expression.
                        if (w_is_term) begin
                            r_state  <= StStart;
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_result <= 16'h0000;
                        end
                    end
                endcase
            end
        end
    end

    assign done   = r_done;
    assign err    = r_err;
    assign result = r_result;

endmodule

// File: tb/tb_expr_eval.sv
// Directed self-checking bench for expr_eval: one task per scenario, hand-computed expectations.
module tb_expr_eval;

    logic        clk;
    logic        clr_n;
    logic        in_valid;
    logic [7:0]  in;
    logic        done;
    logic        err;
    logic [15:0] result;

    int n_checks;
    int n_fail;
    int done_cnt;
    logic [15:0] res_log [0:7];
    logic        err_log [0:7];

    expr_eval dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .in_valid (in_valid),
        .in       (in),
        .done     (done),
        .err      (err),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one character (or an idle cycle) and log any done pulse it produced.
    task automatic send_char(input logic [7:0] c, input logic v);
        in_valid = v;
        in       = c;
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            if (done_cnt < 8) begin
                res_log[done_cnt] = result;
                err_log[done_cnt] = err;
            end
            done_cnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_char(8'h00, 1'b0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
    endtask

    task automatic test_reset;
        clr_n    = 1'b0;
        in_valid = 1'b1;
        in       = "5";
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({done, err, result} !== 18'h0) begin
            $display("FAIL reset_outputs: got done=%b err=%b result=%h, want 0 0 0000",
                     done, err, result);
            n_fail++;
        end
        clr_n    = 1'b1;
        in_valid = 1'b0;
        idle(1);
        n_checks++;
        if (done !== 1'b0) begin
            $display("FAIL reset_no_done: got done=%b, want 0", done);
            n_fail++;
        end
    endtask

    task automatic test_basic;
        done_cnt = 0;
        send_str("1+2*3=");
        n_checks++;
        if (done_cnt !== 1 || res_log[0] !== 16'd9 || err_log[0] !== 1'b0) begin
            $display("FAIL basic_1p2m3: got pulses=%0d result=%h err=%b, want 1 0009 0",
                     done_cnt, res_log[0], err_log[0]);
            n_fail++;
        end
        idle(1);
        n_checks++;
        if (done !== 1'b0 || result !== 16'd9) begin
            $display("FAIL basic_pulse_hold: got done=%b result=%h, want 0 0009", done, result);
            n_fail++;
        end
    endtask

    task automatic test_wrap;
        done_cnt = 0;
        send_str("9-9-9=");
        n_checks++;
        if (done_cnt !== 1 || res_log[0] !== 16'hFFF7 || err_log[0] !== 1'b0) begin
            $display("FAIL wrap_sub: got pulses=%0d result=%h err=%b, want 1 fff7 0",
                     done_cnt, res_log[0], err_log[0]);
            n_fail++;
        end
        done_cnt = 0;
        send_str("9*9*9*9*9*9=");
        n_checks++;
        if (done_cnt !== 1 || res_log[0] !== 16'h1BF1 || err_log[0] !== 1'b0) begin
            $display("FAIL wrap_mul: got pulses=%0d result=%h err=%b, want 1 1bf1 0",
                     done_cnt, res_log[0], err_log[0]);
            n_fail++;
        end
        idle(2);
    endtask

    task automatic test_errors;
        string bad [0:3];
        bad[0] = "12+3=";
        bad[1] = "=";
        bad[2] = "3+=";
        bad[3] = "5+a2=";
        for (int k = 0; k < 4; k++) begin
            done_cnt = 0;
            send_str(bad[k]);
            n_checks++;
            if (done_cnt !== 1 || err_log[0] !== 1'b1 || res_log[0] !== 16'h0) begin
                $display("FAIL err_%s: got pulses=%0d err=%b result=%h, want 1 1 0000",
                         bad[k], done_cnt, err_log[0], res_log[0]);
                n_fail++;
            end
            done_cnt = 0;
            send_str("4=");
            n_checks++;
            if (done_cnt !== 1 || err_log[0] !== 1'b0 || res_log[0] !== 16'd4) begin
                $display("FAIL recover_after_%s: got pulses=%0d err=%b result=%h, want 1 0 0004",
                         bad[k], done_cnt, err_log[0], res_log[0]);
                n_fail++;
            end
            idle(1);
        end
    endtask

    task automatic test_gaps;
        done_cnt = 0;
        send_char("5", 1'b1);
        idle(3);
        send_char("=", 1'b1);
        send_str("2*3=");
        n_checks++;
        if (done_cnt !== 2 || res_log[0] !== 16'd5 || res_log[1] !== 16'd6
            || err_log[0] !== 1'b0 || err_log[1] !== 1'b0) begin
            $display("FAIL gaps_b2b: got pulses=%0d r0=%h e0=%b r1=%h e1=%b, want 2 0005 0 0006 0",
                     done_cnt, res_log[0], err_log[0], res_log[1], err_log[1]);
            n_fail++;
        end
        idle(1);
    endtask

    task automatic test_reset_mid;
        done_cnt = 0;
        send_str("7+");
        clr_n = 1'b0;
        send_char("=", 1'b1);
        n_checks++;
        if ({done, err, result} !== 18'h0 || done_cnt !== 0) begin
            $display("FAIL reset_mid: got done=%b err=%b result=%h pulses=%0d, want 0 0 0000 0",
                     done, err, result, done_cnt);
            n_fail++;
        end
        clr_n = 1'b1;
        send_str("4=");
        n_checks++;
        if (done_cnt !== 1 || res_log[0] !== 16'd4 || err_log[0] !== 1'b0) begin
            $display("FAIL reset_mid_next: got pulses=%0d result=%h err=%b, want 1 0004 0",
                     done_cnt, res_log[0], err_log[0]);
            n_fail++;
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        done_cnt = 0;
        send_char("=", 1'b1);
        n_checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            $display("FAIL eq_first: got done=%b err=%b, want 1 1", done, err);
            n_fail++;
        end
        send_char("=", 1'b1);
        n_checks++;
        if (done !== 1'b1 || err !== 1'b1 || result !== 16'h0) begin
            $display("FAIL eq_second: got done=%b err=%b result=%h, want 1 1 0000",
                     done, err, result);
            n_fail++;
        end
        idle(1);
        n_checks++;
        if (done_cnt !== 2 || done !== 1'b0) begin
            $display("FAIL eq_pulses: got pulses=%0d done=%b, want 2 0", done_cnt, done);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        clr_n    = 1'b0;
        in_valid = 1'b0;
        in       = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_errors();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
